// File: rtl/pw_usb_pkt_framer.sv
// pw_usb_pkt_framer: splits the sniffed USB receive stream into packets, checks PID/CRC/length, emits status.
// Define PW_PKT_FRAMER_SOF_FILTER_EN to drop SOF packet bytes while still reporting their status.
module pw_usb_pkt_framer #(
    parameter int pMAX_PAYLOAD = 1024,
    parameter int pLEN_WIDTH   = 11,
    parameter int pCOUNT_WIDTH = 16
) (
    input  logic                    fe_clk,
    input  logic                    reset_i,
    input  logic                    I_enable,
    input  logic [7:0]              I_sniff_data,
    input  logic                    I_sniff_wr,
    input  logic                    I_rxactive,
    input  logic                    I_rxerror,
    output logic [7:0]              O_data,
    output logic                    O_data_valid,
    output logic                    O_sop,
    output logic                    O_eop,
    output logic [3:0]              O_pid,
    output logic [pLEN_WIDTH-1:0]   O_pkt_len,
    output logic [4:0]              O_status,
    output logic                    O_status_valid,
    output logic [pCOUNT_WIDTH-1:0] O_pkt_count
);
    typedef enum logic [2:0] {WAIT_IDLE, IDLE, PID, BODY, CLOSE} state_t;
    localparam logic [1:0] CL_SPC = 2'd0, CL_TOK = 2'd1, CL_DAT = 2'd2, CL_HSK = 2'd3;
    localparam logic [pLEN_WIDTH-1:0] L1 = pLEN_WIDTH'(1);
    localparam logic [pLEN_WIDTH-1:0] L3 = pLEN_WIDTH'(3);
    localparam logic [pLEN_WIDTH-1:0] LMAX = pLEN_WIDTH'(pMAX_PAYLOAD + 3);
`ifdef PW_PKT_FRAMER_SOF_FILTER_EN
    localparam bit SOF_FILT = 1'b1;
`else
    localparam bit SOF_FILT = 1'b0;
`endif

    state_t                state;
    logic [1:0]            cls;
    logic [4:0]            crc5;
    logic [15:0]           crc16;
    logic [pLEN_WIDTH-1:0] cnt;
    logic                  pid_err, rx_err, sof, drop;
    logic                  len_err, crc_err, ovf;

    function automatic logic [4:0] crc5_step(input logic [4:0] c, input logic [7:0] b);
        logic [4:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 5'h14 : 5'h00);
        return r;
    endfunction

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic [7:0] b);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) r = (r >> 1) ^ ((r[0] ^ b[i]) ? 16'hA001 : 16'h0000);
        return r;
    endfunction

    function automatic logic [1:0] pid_class(input logic [3:0] p);
        case (p)
            4'h1, 4'h9, 4'hD, 4'h5, 4'h4: return CL_TOK;
            4'h3, 4'hB, 4'h7, 4'hF:       return CL_DAT;
            4'h2, 4'hA, 4'hE, 4'h6:       return CL_HSK;
            default:                      return CL_SPC;
        endcase
    endfunction

    // An empty packet (no PID byte) is always a length error.
    always_comb begin
        ovf = cnt > LMAX;
        len_err = (cnt == '0) | (cls == CL_TOK ? cnt != L3 :
                                 cls == CL_HSK ? cnt != L1 :
                                 cls == CL_DAT ? (cnt < L3 || cnt > LMAX) : 1'b0);
        crc_err = ~len_err & (cls == CL_TOK ? crc5 != 5'h06 :
                              cls == CL_DAT ? crc16 != 16'hB001 : 1'b0);
    end

    assign drop = SOF_FILT && I_sniff_data[3:0] == 4'h5;

    always_ff @(posedge fe_clk) begin
        if (!reset_i) begin
            state          <= WAIT_IDLE;
            cls            <= CL_SPC;
            crc5           <= '0;
            crc16          <= '0;
            cnt            <= '0;
            pid_err        <= 1'b0;
            rx_err         <= 1'b0;
            sof            <= 1'b0;
            O_data         <= '0;
            O_data_valid   <= 1'b0;
            O_sop          <= 1'b0;
            O_eop          <= 1'b0;
            O_pid          <= '0;
            O_pkt_len      <= '0;
            O_status       <= '0;
            O_status_valid <= 1'b0;
            O_pkt_count    <= '0;
        end else begin
            O_data_valid   <= 1'b0;
            O_sop          <= 1'b0;
            O_eop          <= 1'b0;
            O_status_valid <= 1'b0;
            if (!I_enable) state <= WAIT_IDLE;
            else case (state)
                WAIT_IDLE: if (!I_rxactive) state <= IDLE;
                IDLE: if (I_rxactive) begin
                    state   <= PID;
                    cnt     <= '0;
                    crc5    <= 5'h1F;
                    crc16   <= 16'hFFFF;
                    cls     <= CL_SPC;
                    pid_err <= 1'b0;
                    rx_err  <= 1'b0;
                    sof     <= 1'b0;
                end
                PID: begin
                    rx_err <= rx_err | I_rxerror;
                    if (I_sniff_wr) begin
                        O_pid   <= I_sniff_data[3:0];
                        pid_err <= I_sniff_data[7:4] != ~I_sniff_data[3:0];
                        cls     <= pid_class(I_sniff_data[3:0]);
                        cnt     <= L1;
                        sof     <= drop;
                        if (!drop) begin
                            O_data       <= I_sniff_data;
                            O_data_valid <= 1'b1;
                            O_sop        <= 1'b1;
                        end
                        state <= I_rxactive ? BODY : CLOSE;
                    end else if (!I_rxactive) state <= CLOSE;
                end
                BODY: begin
                    rx_err <= rx_err | I_rxerror;
                    if (I_sniff_wr) begin
                        cnt   <= cnt + pLEN_WIDTH'(~&cnt);
                        crc5  <= crc5_step(crc5, I_sniff_data);
                        crc16 <= crc16_step(crc16, I_sniff_data);
                        if (!sof) begin
                            O_data       <= I_sniff_data;
                            O_data_valid <= 1'b1;
                        end
                    end
                    if (!I_rxactive) state <= CLOSE;
                end
                CLOSE: begin
                    O_eop          <= 1'b1;
                    O_status_valid <= 1'b1;
                    O_status       <= {rx_err, ovf, len_err, crc_err, pid_err};
                    O_pkt_len      <= cnt;
                    O_pkt_count    <= O_pkt_count + 1'b1;
                    state          <= IDLE;
                end
                default: state <= WAIT_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pw_usb_pkt_framer.sv
// tb_pw_usb_pkt_framer: directed self-checking bench for pw_usb_pkt_framer.
module tb_pw_usb_pkt_framer;
    logic        fe_clk = 1'b0;
    logic        reset_i, I_enable, I_sniff_wr, I_rxactive, I_rxerror;
    logic [7:0]  I_sniff_data;
    logic [7:0]  O_data;
    logic        O_data_valid, O_sop, O_eop, O_status_valid;
    logic [3:0]  O_pid;
    logic [10:0] O_pkt_len;
    logic [4:0]  O_status;
    logic [15:0] O_pkt_count;

    int tests = 0, fails = 0;
    int cyc = 0, drive_cyc, first_v, last_v, eop_cyc, nbytes, nstat, coinc;
    logic [7:0]  sop_byte;
    logic [4:0]  st;
    logic [10:0] ln;
    logic [15:0] pc;
    logic [3:0]  pd;

    pw_usb_pkt_framer dut (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_enable(I_enable),
        .I_sniff_data(I_sniff_data), .I_sniff_wr(I_sniff_wr),
        .I_rxactive(I_rxactive), .I_rxerror(I_rxerror),
        .O_data(O_data), .O_data_valid(O_data_valid), .O_sop(O_sop), .O_eop(O_eop),
        .O_pid(O_pid), .O_pkt_len(O_pkt_len), .O_status(O_status),
        .O_status_valid(O_status_valid), .O_pkt_count(O_pkt_count)
    );

    always #5 fe_clk = ~fe_clk;
    always @(posedge fe_clk) cyc <= cyc + 1;

    always @(negedge fe_clk) begin
        if (O_data_valid) begin
            nbytes <= nbytes + 1;
            last_v <= cyc;
            if (first_v < 0) first_v <= cyc;
        end
        if (O_data_valid && O_sop) sop_byte <= O_data;
        if (O_eop) begin
            eop_cyc <= cyc;
            if (O_data_valid) coinc <= 1;
        end
        if (O_status_valid) begin
            nstat <= nstat + 1;
            st    <= O_status;
            ln    <= O_pkt_len;
            pc    <= O_pkt_count;
            pd    <= O_pid;
        end
    end

    task automatic tick;
        @(posedge fe_clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clr;
        first_v = -1; last_v = -1; eop_cyc = -1; nbytes = 0; nstat = 0; coinc = 0;
        sop_byte = 8'h00; st = 5'h1F; ln = '1; pc = '1; pd = 4'h0;
    endtask

    task automatic pkt(input logic [7:0] b0, b1, b2, input int n, input bit same_fall, input int err_at);
        clr();
        drive_cyc = -1;
        I_rxactive = 1'b1;
        tick();
        for (int i = 0; i < n; i++) begin
            I_sniff_wr   = 1'b1;
            I_sniff_data = i == 0 ? b0 : i == 1 ? b1 : b2;
            I_rxerror    = i == err_at;
            if (i == 0) drive_cyc = cyc;
            if (same_fall && i == n - 1) I_rxactive = 1'b0;
            tick();
        end
        I_sniff_wr = 1'b0;
        I_rxerror  = 1'b0;
        I_rxactive = 1'b0;
        repeat (5) tick();
    endtask

    initial begin
        reset_i = 1'b0; I_enable = 1'b1; I_sniff_wr = 1'b0; I_rxactive = 1'b0;
        I_rxerror = 1'b0; I_sniff_data = 8'h00;
        clr();
        repeat (3) tick();
        chk("reset_outputs", int'({O_data, O_data_valid, O_sop, O_eop, O_pid, O_status, O_status_valid}), 0);
        chk("reset_len_count", int'({O_pkt_len, O_pkt_count}), 0);
        reset_i = 1'b1;
        repeat (2) tick();

        pkt(8'hD2, 8'h00, 8'h00, 1, 1'b0, -1);
        chk("ack_sop_byte", sop_byte, 8'hD2);
        chk("ack_latency", first_v - drive_cyc, 1);
        chk("ack_pid", pd, 2);
        chk("ack_len", ln, 1);
        chk("ack_status", st, 0);
        chk("ack_count", pc, 1);

        pkt(8'h2D, 8'h00, 8'h10, 3, 1'b0, -1);
        chk("setup_pid", pd, 4'hD);
        chk("setup_len", ln, 3);
        chk("setup_status", st, 0);
        chk("setup_count", pc, 2);
        pkt(8'h2D, 8'h00, 8'h11, 3, 1'b0, -1);
        chk("setup_badcrc_status", st, 5'b00010);

        pkt(8'hC3, 8'h00, 8'h00, 3, 1'b0, -1);
        chk("data0_len", ln, 3);
        chk("data0_status", st, 0);
        chk("data0_bytes", nbytes, 3);
        pkt(8'hC3, 8'h00, 8'h01, 3, 1'b0, -1);
        chk("data0_badcrc_status", st, 5'b00010);
        pkt(8'hC3, 8'h00, 8'h00, 1, 1'b0, -1);
        chk("data0_short_status", st, 5'b00100);
        chk("data0_short_len", ln, 1);

        pkt(8'h00, 8'h00, 8'h00, 1, 1'b0, -1);
        chk("badpid_status", st, 5'b00001);

        pkt(8'h4B, 8'h00, 8'h00, 3, 1'b1, 1);
        chk("data1_rxerr_status", st, 5'b10000);
        chk("data1_bytes", nbytes, 3);
        chk("data1_eop_not_coincident", coinc, 0);
        chk("data1_eop_after_last", eop_cyc - last_v, 1);
        chk("data1_nstat", nstat, 1);

        pkt(8'h00, 8'h00, 8'h00, 0, 1'b0, -1);
        chk("empty_status", st, 5'b00100);
        chk("empty_len", ln, 0);

        clr();
        I_rxactive = 1'b1; tick();
        I_sniff_wr = 1'b1; I_sniff_data = 8'h4B; tick();
        I_enable = 1'b0; I_sniff_data = 8'h00; tick();
        I_sniff_wr = 1'b0; I_enable = 1'b1; tick();
        I_rxactive = 1'b0; repeat (5) tick();
        chk("disable_no_status", nstat, 0);

        clr();
        I_rxactive = 1'b1; tick();
        I_sniff_wr = 1'b1; I_sniff_data = 8'h4B; tick();
        I_sniff_data = 8'h00; tick();
        I_sniff_wr = 1'b0; reset_i = 1'b0; tick();
        reset_i = 1'b1; I_sniff_wr = 1'b1; tick();
        I_sniff_wr = 1'b0; tick();
        I_rxactive = 1'b0; repeat (5) tick();
        chk("reset_mid_no_status", nstat, 0);
        pkt(8'hD2, 8'h00, 8'h00, 1, 1'b0, -1);
        chk("post_reset_count", pc, 1);
        chk("post_reset_status", st, 0);

        pkt(8'hA5, 8'h00, 8'h08, 3, 1'b0, -1);
        chk("sof_nstat", nstat, 1);
        chk("sof_count", pc, 2);
        chk("sof_len", ln, 3);
        chk("sof_pid", pd, 5);
`ifdef PW_PKT_FRAMER_SOF_FILTER_EN
        chk("sof_bytes", nbytes, 0);
`else
        chk("sof_bytes", nbytes, 3);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
